// File: rtl/mealy_seq_detector_prog.sv
// Runtime-programmable serial sequence detector with a Mealy match output.
// Progress k counts matched pattern bits. Fallback on a mismatch, and the
// restart point after an overlapping match, are computed combinationally from
// the current pattern. They are therefore valid on the first bit after a load
// or a reset.
module mealy_seq_detector_prog #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 8,
  parameter int DEF_LEN = 4,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'h0B)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               x,
  input  logic               ovl,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cnt_clr,
  output logic               z,
  output logic               z_q,
  output logic               cfg_err,
  output logic [CNT_W-1:0]   match_count
);

  localparam int SW = MAX_LEN + 1;
  localparam int KW = LEN_W + 1;

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   k_q, k_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               z_dly_q, z_dly_d;
  logic               cfg_err_q, cfg_err_d;

  logic [MAX_LEN-1:0] pat_rev;
  logic [MAX_LEN-1:0] pfx;       // pfx[i] = i-th pattern bit in arrival order
  logic [SW-1:0]      pfx_ext;
  logic [SW-1:0]      low_mask;
  logic [SW-1:0]      seq;       // matched prefix followed by the current bit
  logic [KW-1:0]      k_ext, len_ext;
  logic [MAX_LEN:1]   cand_ok;   // cand_ok[j]: prefix of length j is a suffix of seq
  logic [LEN_W-1:0]   kmp_next;
  logic               cfg_len_ok;
  logic [MAX_LEN-1:0] cfg_mask;
  logic               match;

  // The first-received bit sits at pat[len-1], so reversing and shifting
  // yields the pattern in arrival order starting at bit 0.
  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_rev
    assign pat_rev[gi] = pat_q[MAX_LEN-1-gi];
  end

  assign pfx      = pat_rev >> (LEN_W'(MAX_LEN) - len_q);
  assign pfx_ext  = {1'b0, pfx};
  assign low_mask = (SW'(1) << k_q) - SW'(1);
  assign seq      = (pfx_ext & low_mask) | (SW'(x) << k_q);
  assign k_ext    = {1'b0, k_q};
  assign len_ext  = {1'b0, len_q};

  // Each candidate length j must fit in seq and be a proper prefix.
  // Its window, the last j bits of seq, must equal the first j pattern bits.
  for (genvar gi = 1; gi <= MAX_LEN; gi++) begin : g_cand
    localparam logic [KW-1:0] J = KW'(gi);
    localparam logic [SW-1:0] M = SW'((1 << gi) - 1);
    logic [SW-1:0] win;
    assign win = seq >> (k_ext + KW'(1) - J);
    assign cand_ok[gi] = (k_ext + KW'(1) >= J) && (len_ext > J) &&
                         ((win & M) == (pfx_ext & M));
  end

  // Pick the longest valid candidate; 0 if none.
  always_comb begin
    kmp_next = '0;
    for (int j = 1; j <= MAX_LEN; j++) begin
      if (cand_ok[j]) kmp_next = LEN_W'(j);
    end
  end

  assign cfg_len_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
  assign cfg_mask   = MAX_LEN'((SW'(1) << cfg_len) - SW'(1));
  assign match      = en & ~cfg_load & (k_q == len_q - LEN_W'(1)) & (x == pat_q[0]);
  assign z          = match & ~rst;

  // Next-state: configuration load, progress update, delayed z, counter.
  always_comb begin
    pat_d     = pat_q;
    len_d     = len_q;
    k_d       = k_q;
    z_dly_d   = z_dly_q;
    cfg_err_d = 1'b0;
    cnt_d     = cnt_q;
    if (cfg_load) begin
      if (cfg_len_ok) begin
        pat_d = cfg_pattern & cfg_mask;
        len_d = cfg_len;
        k_d   = '0;
      end else begin
        cfg_err_d = 1'b1;
      end
    end else if (en) begin
      if (match && !ovl) k_d = '0;
      else               k_d = kmp_next;
    end
    if (en) z_dly_d = match;
    if (cnt_clr)                   cnt_d = '0;
    else if (match && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  // State registers with asynchronous reset to the default pattern.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q     <= DEF_PATTERN;
      len_q     <= LEN_W'(DEF_LEN);
      k_q       <= '0;
      z_dly_q   <= 1'b0;
      cfg_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pat_q     <= pat_d;
      len_q     <= len_d;
      k_q       <= k_d;
      z_dly_q   <= z_dly_d;
      cfg_err_q <= cfg_err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign z_q         = z_dly_q;
  assign cfg_err     = cfg_err_q;
  assign match_count = cnt_q;

endmodule

// File: tb/tb_mealy_seq_detector_prog.sv
// Bench for mealy_seq_detector_prog: directed scenarios plus a random run.
// The reference model keeps the bit history since the last restart point
// (reset, load, or non-overlapping match). It flags a match when the tail of
// that history equals the pattern.
module tb_mealy_seq_detector_prog;

  localparam int MAX_LEN = 8;

  logic       clk = 1'b0;
  logic       rst, en, x, ovl, cfg_load, cnt_clr;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       z, z_q, cfg_err;
  logic [7:0] match_count;

  int errors = 0;
  int checks = 0;

  bit         hist[$];
  logic [7:0] m_pat;
  int         m_len;
  int         m_cnt;
  bit         m_zq, m_err;

  mealy_seq_detector_prog dut (
    .clk(clk), .rst(rst), .en(en), .x(x), .ovl(ovl), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cnt_clr(cnt_clr),
    .z(z), .z_q(z_q), .cfg_err(cfg_err), .match_count(match_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit model_z(input bit e, input bit xx, input bit ld);
    bit s[$];
    if (!e || ld) return 1'b0;
    s = hist;
    s.push_back(xx);
    if (s.size() < m_len) return 1'b0;
    for (int i = 0; i < m_len; i++)
      if (s[s.size() - m_len + i] != m_pat[m_len-1-i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_pat = 8'h0B;
    m_len = 4;
    m_cnt = 0;
    m_zq  = 1'b0;
    m_err = 1'b0;
  endtask

  // One clock cycle: drive at negedge, check z combinationally, then update
  // the model at the posedge and check the registered outputs.
  task automatic cyc(input bit e, input bit xx, input bit o = 1'b1, input bit ld = 1'b0,
                     input logic [7:0] p = 8'h00, input logic [3:0] l = 4'd0,
                     input bit clr = 1'b0);
    bit ez;
    bit legal;
    @(negedge clk);
    en = e; x = xx; ovl = o; cfg_load = ld; cfg_pattern = p; cfg_len = l; cnt_clr = clr;
    #1;
    ez = model_z(e, xx, ld);
    chk("z", z, ez);
    @(posedge clk);
    legal = (l != 0) && (l <= MAX_LEN);
    if (ld) begin
      if (legal) begin
        m_len = l;
        m_pat = p & 8'((9'd1 << l) - 9'd1);
        hist.delete();
      end
      m_err = !legal;
    end else begin
      m_err = 1'b0;
      if (e) begin
        hist.push_back(xx);
        if (ez && !o) hist.delete();
        while (hist.size() > MAX_LEN) void'(hist.pop_front());
      end
    end
    if (e) m_zq = ez;
    if (clr) m_cnt = 0;
    else if (ez && m_cnt < 255) m_cnt++;
    #1;
    chk("z_q", z_q, m_zq);
    chk("cfg_err", cfg_err, m_err);
    chk("match_count", match_count, m_cnt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b1; x = 1'b1; cfg_load = 1'b0; cnt_clr = 1'b0;
    #1;
    chk("rst_z", z, 0);
    chk("rst_z_q", z_q, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_count", match_count, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; en = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
    model_reset();
  endtask

  task automatic send(input logic [31:0] v, input int n, input bit o);
    for (int i = n - 1; i >= 0; i--) cyc(1'b1, v[i], o);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; x = 1'b0; ovl = 1'b1; cfg_load = 1'b0;
    cfg_pattern = 8'h00; cfg_len = 4'd0; cnt_clr = 1'b0;
    model_reset();

    // Default 1011, overlapping: z on bits 4 and 7.
    do_reset();
    send(32'b1011011, 7, 1'b1);
    chk("t1_count", match_count, 2);

    // Non-overlapping: bit 7 needs fresh bits; 10111011 gives two matches.
    do_reset();
    send(32'b1011011, 7, 1'b0);
    chk("t2a_count", match_count, 1);
    do_reset();
    send(32'b10111011, 8, 1'b0);
    chk("t2b_count", match_count, 2);

    // Pattern 111: overlapping gives 3 matches in 5 ones; non-overlapping gives 1, then 1 more on bit 6.
    do_reset();
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h07, 4'd3);
    send(32'b11111, 5, 1'b1);
    chk("t3a_count", match_count, 3);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h07, 4'd3);
    send(32'b111111, 6, 1'b0);
    chk("t3b_count", match_count, 5);

    // Idle cycles inside a sequence, then a reload that discards progress.
    do_reset();
    cyc(1'b1, 1'b1); cyc(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'($urandom_range(0, 1)));
    cyc(1'b1, 1'b1); cyc(1'b1, 1'b1);
    chk("t4a_count", match_count, 1);
    cyc(1'b1, 1'b1); cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'h0B, 4'd4);
    cyc(1'b1, 1'b1); cyc(1'b1, 1'b1);
    chk("t4b_count", match_count, 1);

    // Illegal lengths are rejected; reset discards partial progress.
    do_reset();
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 4'd0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, 4'd9);
    send(32'b1011, 4, 1'b1);
    chk("t5a_count", match_count, 1);
    send(32'b101, 3, 1'b1);
    do_reset();
    cyc(1'b1, 1'b1);
    chk("t5b_count", match_count, 0);

    // Single-bit pattern, counter saturation, clear beats a match.
    do_reset();
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 4'd1);
    send(32'b101, 3, 1'b1);
    chk("t6a_count", match_count, 2);
    for (int i = 0; i < 260; i++) cyc(1'b1, 1'b1, 1'($urandom_range(0, 1)));
    chk("t6b_sat", match_count, 255);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1);
    chk("t6c_clr", match_count, 0);

    // Random traffic with occasional loads (legal and illegal), clears and resets.
    do_reset();
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          $urandom_range(0, 19) == 0, 8'($urandom), 4'($urandom_range(0, 10)),
          $urandom_range(0, 49) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
